// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch path.
package riscv_pkg;

  localparam int XLEN = 32;

  // Instruction presented to decode while the prefetch buffer is empty (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One prefetch buffer entry: fetched word plus the PC it was fetched from.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous active-low reset and flush.
// Push into a full FIFO and pop from an empty FIFO are ignored; flush wins over both.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted push, never reset (contents qualified by count).
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: issues word fetches to a variable-latency imem,
// tracks in-flight PCs, buffers returned words and hands them to decode.
// EX redirects flush the buffer and discard responses already in flight.
// XLEN must match riscv_pkg::XLEN since buffer entries use fetch_entry_t.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN            = riscv_pkg::XLEN,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = ((OW > FCW) ? OW : FCW) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_next;
  logic [OW-1:0]   drop_cnt;

  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_keep;
  logic            id_fire;
  logic [SW-1:0]   credit_used;

  logic [XLEN-1:0] rsp_pc;
  logic [OW-1:0]   pcq_count;
  logic            pcq_full;
  logic            pcq_empty;

  fetch_entry_t    buf_in;
  fetch_entry_t    buf_head;
  logic [FCW-1:0]  buf_count;
  logic            buf_full;
  logic            buf_empty;

  // Credit rule: every in-flight request already owns a buffer slot, so the
  // buffer can never overflow however late decode drains it.
  assign credit_used    = SW'(outstanding) + SW'(buf_count);
  assign imem_req_valid = !redirect_valid
                          && (outstanding < OW'(MAX_OUTSTANDING))
                          && (credit_used < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_ok && (drop_cnt == '0) && !redirect_valid;
  assign id_fire  = id_valid && id_ready;

  assign outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_ok);

  assign buf_in.instr = imem_rsp_data;
  assign buf_in.pc    = rsp_pc;

  // PCs of accepted requests, popped in order as responses arrive (also for dropped ones).
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_ok),
    .pop_data  (rsp_pc),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  // Prefetch buffer feeding decode; a redirect flushes it and beats any pop.
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_in),
    .pop       (id_fire),
    .pop_data  (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Queue status mirrors the counters above; kept only for observability.
  logic unused_status;
  assign unused_status = ^{pcq_count, pcq_full, pcq_empty, buf_full};

  assign id_valid    = !buf_empty;
  assign id_instr    = buf_empty ? NOP_INSTR : buf_head.instr;
  assign id_pc       = buf_empty ? '0 : buf_head.pc;
  assign id_pc_plus4 = id_pc + XLEN'(4);

  // Fetch PC, in-flight count and stale-response drop count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: a behavioural imem with in-order
// variable latency plus an architectural model of the expected fetch stream.
module tb_riscv_fetch_unit;

  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  always #5 clock = ~clock;

  riscv_fetch_unit #(
    .XLEN            (32),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  int total = 0;
  int bad   = 0;

  // memory model: in-flight request addresses with the cycle their response is due
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // architectural expectations
  logic [31:0] exp_req_pc;
  logic [31:0] exp_id_pc;
  logic        prev_stall;
  int          pops;
  logic        s_fire;
  logic [31:0] s_pc;
  logic        hit_redir;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive at negedge, check and update the model 1ns later.
  task automatic step(input logic rst_n, input logic rdy, input logic idr,
                      input logic redir, input logic [31:0] rpc, input logic auto_redir);
    logic rd;
    int   n0;
    @(negedge clock);
    reset          = rst_n;
    imem_req_ready = rdy;
    id_ready       = idr;
    rd             = redir;
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
    end
    if (rst_n && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (auto_redir && id_valid && idr && imem_rsp_valid && mq_addr.size() == MAXO) rd = 1'b1;
    redirect_valid = rd;
    redirect_pc    = rpc;
    hit_redir      = rd;
    s_fire         = 1'b0;
    #1;
    if (!rst_n) begin
      exp_req_pc = RESET_PC;
      exp_id_pc  = RESET_PC;
      prev_stall = 1'b0;
    end else begin
      n0 = mq_addr.size();
      if (rd) check_eq("req_withdraw", imem_req_valid, 0);
      if (prev_stall && !rd) check_eq("req_hold", imem_req_valid, 1);
      if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_req_pc);
      if (imem_rsp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && rdy) begin
        check_eq("outstanding_cap", n0 < MAXO, 1);
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + $urandom_range(lat_lo, lat_hi));
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (rd) begin
        exp_req_pc = {rpc[31:2], 2'b00};
        exp_id_pc  = {rpc[31:2], 2'b00};
      end else if (id_valid && idr) begin
        check_eq("id_pc", id_pc, exp_id_pc);
        check_eq("id_instr", id_instr, mem_word(exp_id_pc));
        check_eq("id_pc_plus4", id_pc_plus4, exp_id_pc + 32'd4);
        s_fire    = 1'b1;
        s_pc      = id_pc;
        pops++;
        exp_id_pc = exp_id_pc + 32'd4;
      end
      if (!id_valid) begin
        check_eq("idle_instr", id_instr, NOP);
        check_eq("idle_pc", id_pc, 0);
      end
      prev_stall = imem_req_valid && !rdy;
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    exp_req_pc = RESET_PC; exp_id_pc = RESET_PC; prev_stall = 1'b0;
    s_fire = 1'b0; s_pc = '0; hit_redir = 1'b0; pops = 0;

    repeat (3) step(0, 1, 1, 0, 0, 0);

    // reset state and zero-wait streaming
    pops = 0;
    step(1, 1, 1, 0, 0, 0);
    check_eq("rst_id_valid", id_valid, 0);
    check_eq("rst_id_instr", id_instr, NOP);
    check_eq("rst_id_pc", id_pc, 0);
    check_eq("rst_req_valid", imem_req_valid, 1);
    check_eq("rst_req_addr", imem_req_addr, RESET_PC);
    repeat (19) step(1, 1, 1, 0, 0, 0);
    check_eq("t1_throughput", pops, 18);

    // decode stall fills the buffer, then it drains in order
    repeat (10) step(1, 1, 0, 0, 0, 0);
    check_eq("t2_req_stop", imem_req_valid, 0);
    check_eq("t2_buf_valid", id_valid, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, 0, 0);
      check_eq("t2_drain", s_fire, 1);
    end

    // redirect with two late responses in flight
    lat_lo = 3; lat_hi = 3;
    n = 0;
    while (mq_addr.size() != MAXO && n < 40) begin step(1, 1, 1, 0, 0, 0); n++; end
    check_eq("t3_fill_timeout", n < 40, 1);
    step(1, 1, 1, 1, 32'h0000_0100, 0);
    n = 0; s_fire = 1'b0;
    while (!s_fire && n < 40) begin step(1, 1, 1, 0, 0, 0); n++; end
    check_eq("t3_fire_timeout", n < 40, 1);
    check_eq("t3_first_pc", s_pc, 32'h0000_0100);

    // redirect coinciding with a response and a decode pop
    lat_lo = 2; lat_hi = 3;
    n = 0; hit_redir = 1'b0;
    while (!hit_redir && n < 300) begin
      step(1, 1, 1'($urandom_range(0, 1)), 0, 32'h0000_0400, 1);
      n++;
    end
    check_eq("t4_hit_timeout", n < 300, 1);
    step(1, 1, 1, 0, 0, 0);
    check_eq("t4_flush", id_valid, 0);
    n = 0; s_fire = 1'b0;
    while (!s_fire && n < 40) begin step(1, 1, 1, 0, 0, 0); n++; end
    check_eq("t4_fire_timeout", n < 40, 1);
    check_eq("t4_first_pc", s_pc, 32'h0000_0400);

    // memory not ready: request held, then withdrawn by a misaligned redirect
    lat_lo = 1; lat_hi = 1;
    n = 0;
    step(1, 0, 1, 0, 0, 0);
    while (!imem_req_valid && n < 20) begin step(1, 0, 1, 0, 0, 0); n++; end
    check_eq("t5_valid_timeout", n < 20, 1);
    repeat (5) begin
      step(1, 0, 1, 0, 0, 0);
      check_eq("t5_hold_valid", imem_req_valid, 1);
      check_eq("t5_hold_addr", imem_req_addr, exp_req_pc);
    end
    step(1, 0, 1, 1, 32'h0000_0203, 0);
    check_eq("t5_withdraw", imem_req_valid, 0);
    step(1, 0, 1, 0, 0, 0);
    check_eq("t5_new_valid", imem_req_valid, 1);
    check_eq("t5_new_addr", imem_req_addr, 32'h0000_0200);
    repeat (8) step(1, 1, 1, 0, 0, 0);

    // PC wraps past the top of the address space
    step(1, 1, 1, 1, 32'hFFFF_FFF9, 0);
    repeat (12) step(1, 1, 1, 0, 0, 0);

    // reset with two requests in flight
    lat_lo = 3; lat_hi = 3;
    n = 0;
    while (mq_addr.size() != MAXO && n < 40) begin step(1, 1, 1, 0, 0, 0); n++; end
    check_eq("t6_fill_timeout", n < 40, 1);
    repeat (2) step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    check_eq("t6_id_valid", id_valid, 0);
    check_eq("t6_req_valid", imem_req_valid, 1);
    check_eq("t6_req_addr", imem_req_addr, RESET_PC);
    repeat (10) step(1, 1, 1, 0, 0, 0);

    // randomized traffic: latency, backpressure and redirects
    lat_lo = 1; lat_hi = 4;
    repeat (1500) begin
      step(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 24) == 0), $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
